radix4_butterfly_pipe: RTL and testbench
========================================

Name: radix4_butterfly_pipe

Overview:
Parametrised, flow-controlled radix-4 DIF butterfly array for the FFT datapath. Computes N_POINT/4 independent radix-4 butterflies per beat, with forward/inverse selection, per-beat right-shift scaling with rounding, and saturation to a configurable output width. Two-stage pipeline with valid/ready handshake. Sits between the input reorder buffer and the twiddle complex multiplier of each FFT stage.

Parameters:
DATA_WIDTH, 8, signed width of each input real/imag sample
N_POINT, 4, samples per beat; multiple of 4; N_DIV = N_POINT/4 butterflies
OUT_WIDTH, DATA_WIDTH+2, signed width of each output sample; range 2..DATA_WIDTH+2
MAX_SCALE, 2, largest shift accepted on scale_i; range 0..2

Ports:
sys_clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
valid_i  in  1  input beat valid
ready_o  out  1  block can accept a beat
inverse_i  in  1  1 = IFFT kernel (+j rotation), sampled with the beat
scale_i  in  2  right shift 0..MAX_SCALE, sampled with the beat
xn_real_i  in  DATA_WIDTH*N_POINT  real samples; lane k at [DATA_WIDTH*k +: DATA_WIDTH]
xn_imag_i  in  DATA_WIDTH*N_POINT  imaginary samples, same packing
valid_o  out  1  output beat valid
ready_i  in  1  downstream accepts
xk_real_o  out  OUT_WIDTH*N_POINT  real results, lane k at [OUT_WIDTH*k +: OUT_WIDTH]
xk_imag_o  out  OUT_WIDTH*N_POINT  imaginary results

Behaviour:
- Operands for butterfly i (0..N_DIV-1): x1=lane i, x2=lane i+N_DIV, x3=lane i+2N_DIV, x4=lane i+3N_DIV.
- Stage 1 (registered, widths DATA_WIDTH+1): A=x1+x3, B=x2+x4, C=x1-x3, D=x2-x4 (complex). inverse and scale are pipelined alongside.
- Stage 2 (registered, full width DATA_WIDTH+2): X0=A+B to lane i; X2=A-B to lane i+N_DIV.
- Forward: X1=(Cr+Di, Ci-Dr) to lane i+2N_DIV; X3=(Cr-Di, Ci+Dr) to lane i+3N_DIV. Inverse: X1 and X3 formulas swapped.
- Scaling, in stage 2 on each full-width result: s=0 passes through; s>0 computes (v + 2^(s-1)) >>> s (arithmetic shift, round half up). scale_i > MAX_SCALE is clamped to MAX_SCALE.
- Saturation: scaled value outside the OUT_WIDTH signed range clamps to max/min; with the default OUT_WIDTH this never triggers.
- Handshake: advance = !valid_o | ready_i; ready_o = advance. On advance, stage 1 loads the input and its valid (valid_i), and stage 2 loads stage 1. When !advance, both stages hold, and data and valid_o stay stable. Latency: 2 cycles from accepted beat to valid_o with no backpressure. Throughput: 1 beat/cycle.
- A beat is accepted only when valid_i & ready_o. Data is not required to be stable when valid_i=0.
- Reset: valid_o=0, stage-1 valid=0, xk_real_o=0, xk_imag_o=0, all pipeline data registers 0, and ready_o=1 immediately. Asserting reset mid-stream discards in-flight beats.
- Simultaneous accept and output consume in the same cycle is normal streaming. No bubbles are inserted.

Optional Feature:
R4_BFLY_OVF_FLAG_EN: adds output ovf_o (1 bit) and input ovf_clr_i (1 bit). ovf_o is sticky and is set on the cycle after any stage-2 load in which a valid beat saturated any lane. ovf_clr_i clears it; if a set and a clear occur in the same cycle, set wins. ovf_o resets to 0. Without the macro, neither port exists and no overflow logic is built.

Test Plan:
Use DATA_WIDTH=8 and N_POINT=4 unless noted.
- Forward DFT: real={1,2,3,4}, imag=0, scale 0, forward -> xk={(10,0),(-2,0),(-2,2),(-2,-2)}, valid_o exactly 2 cycles after accept.
- Inverse: same input with inverse_i=1 -> lane2=(-2,-2), lane3=(-2,2); lanes 0 and 1 unchanged.
- Scaling/rounding: all real=127, scale 2 -> lane0 real=(508+2)>>>2=127; all real=-128, scale 1 -> lane0=-256; scale_i=3 behaves as 2.
- Saturation: OUT_WIDTH=8, all real=127, scale 0 -> lane0 real=127 (clamped); with the macro enabled, ovf_o=1 until ovf_clr_i, and a later clean beat does not clear it.
- Backpressure: stream 6 beats with ready_i toggled in a 1-0-1-1-0 pattern -> all 6 beats are output in order, none dropped or duplicated, outputs stable while stalled, and ready_o low only when valid_o & !ready_i.
- Reset mid-stream: assert rst_n_i low with 2 beats in flight -> valid_o=0 and outputs 0 asynchronously; the first beat after release appears 2 cycles after accept.

Source files
------------

// File: rtl/radix4_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// radix4_butterfly_pipe
//
// Purpose:
//   Array of N_POINT/4 independent radix-4 DIF butterflies evaluated on every
//   beat. It supports forward/inverse kernels, a per-beat right shift with
//   round-half-up, and saturation to OUT_WIDTH. The two-stage pipeline uses a
//   valid/ready handshake.
//
// Ports:
//   sys_clk_i   - clock, rising edge
//   rst_n_i     - asynchronous active-low reset
//   valid_i     - input beat valid
//   ready_o     - block can accept a beat (= !valid_o | ready_i)
//   inverse_i   - 1 selects the IFFT kernel (+j rotation), sampled with beat
//   scale_i     - right shift 0..MAX_SCALE (larger values clamp), sampled
//   xn_real_i   - real samples, lane k at [DATA_WIDTH*k +: DATA_WIDTH]
//   xn_imag_i   - imaginary samples, same packing
//   valid_o     - output beat valid
//   ready_i     - downstream accepts
//   xk_real_o   - real results, lane k at [OUT_WIDTH*k +: OUT_WIDTH]
//   xk_imag_o   - imaginary results, same packing
//   ovf_o       - sticky saturation flag (only with R4_BFLY_OVF_FLAG_EN)
//   ovf_clr_i   - clears ovf_o; a simultaneous set wins (only with macro)
//
// Optional feature macro: R4_BFLY_OVF_FLAG_EN
// ---------------------------------------------------------------------------
module radix4_butterfly_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int N_POINT    = 4,
  parameter int OUT_WIDTH  = DATA_WIDTH + 2,
  parameter int MAX_SCALE  = 2
) (
  input  logic                            sys_clk_i,
  input  logic                            rst_n_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic                            inverse_i,
  input  logic [1:0]                      scale_i,
  input  logic [DATA_WIDTH*N_POINT-1:0]   xn_real_i,
  input  logic [DATA_WIDTH*N_POINT-1:0]   xn_imag_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [OUT_WIDTH*N_POINT-1:0]    xk_real_o,
  output logic [OUT_WIDTH*N_POINT-1:0]    xk_imag_o
`ifdef R4_BFLY_OVF_FLAG_EN
  ,
  output logic                            ovf_o,
  input  logic                            ovf_clr_i
`endif
);

  localparam int N_DIV  = N_POINT / 4;
  localparam int S1_W   = DATA_WIDTH + 1;
  localparam int FULL_W = DATA_WIDTH + 2;
  // One guard bit above full width so the rounding bias cannot wrap.
  localparam int RND_W  = DATA_WIDTH + 3;
  localparam logic signed [RND_W-1:0] OUT_MAX = RND_W'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RND_W-1:0] OUT_MIN = RND_W'(-(2 ** (OUT_WIDTH - 1)));

  logic       advance;
  logic [1:0] scale_clamped;

  logic                    s1_valid;
  logic                    s1_inverse;
  logic [1:0]              s1_scale;
  logic signed [S1_W-1:0]  a_re [N_DIV];
  logic signed [S1_W-1:0]  a_im [N_DIV];
  logic signed [S1_W-1:0]  b_re [N_DIV];
  logic signed [S1_W-1:0]  b_im [N_DIV];
  logic signed [S1_W-1:0]  c_re [N_DIV];
  logic signed [S1_W-1:0]  c_im [N_DIV];
  logic signed [S1_W-1:0]  d_re [N_DIV];
  logic signed [S1_W-1:0]  d_im [N_DIV];

  logic signed [FULL_W-1:0]          full_re [4];
  logic signed [FULL_W-1:0]          full_im [4];
  logic signed [RND_W-1:0]           sc_re;
  logic signed [RND_W-1:0]           sc_im;
  logic [OUT_WIDTH*N_POINT-1:0]      nxt_re;
  logic [OUT_WIDTH*N_POINT-1:0]      nxt_im;
`ifdef R4_BFLY_OVF_FLAG_EN
  logic                              nxt_sat;
`endif

  // Both stages move together; the pipe only stalls when a result is held.
  assign advance = !valid_o || ready_i;
  assign ready_o = advance;

  assign scale_clamped = (int'(scale_i) > MAX_SCALE) ? 2'(MAX_SCALE) : scale_i;

  function automatic logic signed [S1_W-1:0] lane_in(
    input logic [DATA_WIDTH*N_POINT-1:0] bus, input int k);
    logic signed [DATA_WIDTH-1:0] raw;
    raw     = bus[DATA_WIDTH*k +: DATA_WIDTH];
    lane_in = raw;
  endfunction

  function automatic logic signed [FULL_W-1:0] widen(input logic signed [S1_W-1:0] v);
    widen = v;
  endfunction

  function automatic logic signed [RND_W-1:0] scale_round(
    input logic signed [FULL_W-1:0] v, input logic [1:0] s);
    logic signed [RND_W-1:0] ext;
    logic signed [RND_W-1:0] bias;
    ext = v;
    case (s)
      2'd0:    bias = '0;
      2'd1:    bias = RND_W'(1);
      default: bias = RND_W'(2);
    endcase
    scale_round = (ext + bias) >>> s;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] clamp_out(input logic signed [RND_W-1:0] v);
    if (v > OUT_MAX)      clamp_out = OUT_MAX[OUT_WIDTH-1:0];
    else if (v < OUT_MIN) clamp_out = OUT_MIN[OUT_WIDTH-1:0];
    else                  clamp_out = v[OUT_WIDTH-1:0];
  endfunction

  // Stage 1: first radix-2 layer (sums/differences of lanes N_DIV*2 apart).
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid   <= 1'b0;
      s1_inverse <= 1'b0;
      s1_scale   <= '0;
      for (int i = 0; i < N_DIV; i++) begin
        a_re[i] <= '0; a_im[i] <= '0; b_re[i] <= '0; b_im[i] <= '0;
        c_re[i] <= '0; c_im[i] <= '0; d_re[i] <= '0; d_im[i] <= '0;
      end
    end else if (advance) begin
      s1_valid   <= valid_i;
      s1_inverse <= inverse_i;
      s1_scale   <= scale_clamped;
      for (int i = 0; i < N_DIV; i++) begin
        a_re[i] <= lane_in(xn_real_i, i) + lane_in(xn_real_i, i + 2*N_DIV);
        a_im[i] <= lane_in(xn_imag_i, i) + lane_in(xn_imag_i, i + 2*N_DIV);
        b_re[i] <= lane_in(xn_real_i, i + N_DIV) + lane_in(xn_real_i, i + 3*N_DIV);
        b_im[i] <= lane_in(xn_imag_i, i + N_DIV) + lane_in(xn_imag_i, i + 3*N_DIV);
        c_re[i] <= lane_in(xn_real_i, i) - lane_in(xn_real_i, i + 2*N_DIV);
        c_im[i] <= lane_in(xn_imag_i, i) - lane_in(xn_imag_i, i + 2*N_DIV);
        d_re[i] <= lane_in(xn_real_i, i + N_DIV) - lane_in(xn_real_i, i + 3*N_DIV);
        d_im[i] <= lane_in(xn_imag_i, i + N_DIV) - lane_in(xn_imag_i, i + 3*N_DIV);
      end
    end
  end

  // Stage 2 datapath: second layer, then shift/round and saturate per lane.
  // full_* slot q lands on output lane i + q*N_DIV, i.e. slots hold
  // X0, X2, X1, X3 in that order (bit-reversed DIF output ordering).
  always_comb begin
    nxt_re = '0;
    nxt_im = '0;
    sc_re  = '0;
    sc_im  = '0;
`ifdef R4_BFLY_OVF_FLAG_EN
    nxt_sat = 1'b0;
`endif
    for (int q = 0; q < 4; q++) begin
      full_re[q] = '0;
      full_im[q] = '0;
    end
    for (int i = 0; i < N_DIV; i++) begin
      full_re[0] = widen(a_re[i]) + widen(b_re[i]);
      full_im[0] = widen(a_im[i]) + widen(b_im[i]);
      full_re[1] = widen(a_re[i]) - widen(b_re[i]);
      full_im[1] = widen(a_im[i]) - widen(b_im[i]);
      // Inverse kernel rotates by +j instead of -j, which swaps X1 and X3.
      if (s1_inverse) begin
        full_re[2] = widen(c_re[i]) - widen(d_im[i]);
        full_im[2] = widen(c_im[i]) + widen(d_re[i]);
        full_re[3] = widen(c_re[i]) + widen(d_im[i]);
        full_im[3] = widen(c_im[i]) - widen(d_re[i]);
      end else begin
        full_re[2] = widen(c_re[i]) + widen(d_im[i]);
        full_im[2] = widen(c_im[i]) - widen(d_re[i]);
        full_re[3] = widen(c_re[i]) - widen(d_im[i]);
        full_im[3] = widen(c_im[i]) + widen(d_re[i]);
      end
      for (int q = 0; q < 4; q++) begin
        sc_re = scale_round(full_re[q], s1_scale);
        sc_im = scale_round(full_im[q], s1_scale);
        nxt_re[OUT_WIDTH*(i + q*N_DIV) +: OUT_WIDTH] = clamp_out(sc_re);
        nxt_im[OUT_WIDTH*(i + q*N_DIV) +: OUT_WIDTH] = clamp_out(sc_im);
`ifdef R4_BFLY_OVF_FLAG_EN
        if (sc_re > OUT_MAX || sc_re < OUT_MIN || sc_im > OUT_MAX || sc_im < OUT_MIN)
          nxt_sat = 1'b1;
`endif
      end
    end
  end

  // Stage 2 registers double as the output registers.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o   <= 1'b0;
      xk_real_o <= '0;
      xk_imag_o <= '0;
    end else if (advance) begin
      valid_o   <= s1_valid;
      xk_real_o <= nxt_re;
      xk_imag_o <= nxt_im;
    end
  end

`ifdef R4_BFLY_OVF_FLAG_EN
  // Sticky overflow: set by any valid beat that saturated on its way into
  // stage 2; the set branch is checked first so it beats a coincident clear.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                        ovf_o <= 1'b0;
    else if (advance && s1_valid && nxt_sat) ovf_o <= 1'b1;
    else if (ovf_clr_i)                  ovf_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_radix4_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// tb_radix4_butterfly_pipe
//
// Purpose:
//   Self-checking bench for radix4_butterfly_pipe. Two instances share the
//   same stimulus and handshake: "dut" with the default OUT_WIDTH (10) and
//   "dut_sat" with OUT_WIDTH=8 so that saturation is reachable. Expected
//   results come from a direct 4-point DFT model (sum of x_n * (-/+j)^(nk)).
//
// Optional feature macro: R4_BFLY_OVF_FLAG_EN (enables the ovf_o checks)
// ---------------------------------------------------------------------------
module tb_radix4_butterfly_pipe;

  localparam int DW   = 8;
  localparam int NP   = 4;
  localparam int OW   = DW + 2;
  localparam int OW_S = 8;

  typedef struct packed {
    logic        inv;
    logic [1:0]  sc;
    logic [31:0] re;
    logic [31:0] im;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_i = 1'b0;
  logic             inverse = 1'b0;
  logic [1:0]       scale = 2'd0;
  logic [DW*NP-1:0] xr = '0;
  logic [DW*NP-1:0] xi = '0;
  logic             ready_i = 1'b1;
  logic             ready_o, valid_o;
  logic [OW*NP-1:0] yr, yi;
  logic             s_ready_o, s_valid_o;
  logic [OW_S*NP-1:0] sr, si;
`ifdef R4_BFLY_OVF_FLAG_EN
  logic             ovf, s_ovf;
  logic             ovf_clr = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  radix4_butterfly_pipe #(.DATA_WIDTH(DW), .N_POINT(NP), .OUT_WIDTH(OW), .MAX_SCALE(2)) dut (
    .sys_clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .inverse_i(inverse), .scale_i(scale), .xn_real_i(xr), .xn_imag_i(xi),
    .valid_o(valid_o), .ready_i(ready_i), .xk_real_o(yr), .xk_imag_o(yi)
`ifdef R4_BFLY_OVF_FLAG_EN
    , .ovf_o(ovf), .ovf_clr_i(ovf_clr)
`endif
  );

  radix4_butterfly_pipe #(.DATA_WIDTH(DW), .N_POINT(NP), .OUT_WIDTH(OW_S), .MAX_SCALE(2)) dut_sat (
    .sys_clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(s_ready_o),
    .inverse_i(inverse), .scale_i(scale), .xn_real_i(xr), .xn_imag_i(xi),
    .valid_o(s_valid_o), .ready_i(ready_i), .xk_real_o(sr), .xk_imag_o(si)
`ifdef R4_BFLY_OVF_FLAG_EN
    , .ovf_o(s_ovf), .ovf_clr_i(ovf_clr)
`endif
  );

  // Reference model: output lane group g holds DFT bin k = {0,2,1,3}[g].
  function automatic int model_out(beat_t b, int lane, bit want_imag, int ow);
    int ndiv, i, k, sr_acc, si_acc, x_r, x_i, m, t_r, t_i, v, s, hi, lo;
    ndiv = NP / 4;
    i = lane % ndiv;
    case (lane / ndiv)
      0: k = 0;
      1: k = 2;
      2: k = 1;
      default: k = 3;
    endcase
    sr_acc = 0; si_acc = 0;
    for (int n = 0; n < 4; n++) begin
      x_r = int'($signed(b.re[DW*(i + n*ndiv) +: DW]));
      x_i = int'($signed(b.im[DW*(i + n*ndiv) +: DW]));
      m = (n * k) % 4;
      if (!b.inv) m = (4 - m) % 4;
      case (m)
        0: begin t_r = x_r;  t_i = x_i;  end
        1: begin t_r = -x_i; t_i = x_r;  end
        2: begin t_r = -x_r; t_i = -x_i; end
        default: begin t_r = x_i; t_i = -x_r; end
      endcase
      sr_acc += t_r;
      si_acc += t_i;
    end
    v = want_imag ? si_acc : sr_acc;
    s = (b.sc > 2) ? 2 : int'(b.sc);
    if (s > 0) v = (v + (1 << (s - 1))) >>> s;
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return v;
  endfunction

  function automatic logic [31:0] pack4(int a, int b, int c, int d);
    logic [31:0] r;
    r[7:0] = 8'(a); r[15:8] = 8'(b); r[23:16] = 8'(c); r[31:24] = 8'(d);
    return r;
  endfunction

  function automatic int got_r(int l);
    logic signed [OW-1:0] t;
    t = yr[OW*l +: OW];
    return int'(t);
  endfunction
  function automatic int got_i(int l);
    logic signed [OW-1:0] t;
    t = yi[OW*l +: OW];
    return int'(t);
  endfunction
  function automatic int got_sr(int l);
    logic signed [OW_S-1:0] t;
    t = sr[OW_S*l +: OW_S];
    return int'(t);
  endfunction
  function automatic int got_si(int l);
    logic signed [OW_S-1:0] t;
    t = si[OW_S*l +: OW_S];
    return int'(t);
  endfunction

  task automatic present(input beat_t b);
    valid_i = 1'b1; inverse = b.inv; scale = b.sc; xr = b.re; xi = b.im;
  endtask

  // Presents one beat now (caller is #1 after an edge) and polls for valid_o;
  // returns the cycle count, or -1 when nothing appears within the budget.
  task automatic send_single(input beat_t b, output int lat);
    present(b);
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) valid_i = 1'b0;
      if (valid_o) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    #2;
    checks += 4;
    if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", valid_o); end
    if (yr !== '0 || yi !== '0) begin errors++; $display("[TB] FAIL reset_data got=%h/%h want=0", yr, yi); end
    if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b want=1", ready_o); end
    if (s_valid_o !== 1'b0 || sr !== '0) begin errors++; $display("[TB] FAIL reset_sat got=%b/%h want=0", s_valid_o, sr); end
`ifdef R4_BFLY_OVF_FLAG_EN
    checks++;
    if (ovf !== 1'b0 || s_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got=%b/%b want=0", ovf, s_ovf); end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_kernel(input bit inv);
    int lat;
    int exp_r [4];
    int exp_i [4];
    beat_t b;
    exp_r = '{10, -2, -2, -2};
    if (inv) exp_i = '{0, 0, -2, 2};
    else     exp_i = '{0, 0, 2, -2};
    b = '{inv: inv, sc: 2'd0, re: pack4(1, 2, 3, 4), im: 32'h0};
    ready_i = 1'b1;
    send_single(b, lat);
    checks++;
    if (lat != 2) begin errors++; $display("[TB] FAIL kernel%0d_latency got=%0d want=2", inv, lat); end
    for (int l = 0; l < 4; l++) begin
      checks += 2;
      if (got_r(l) != exp_r[l]) begin errors++; $display("[TB] FAIL kernel%0d_re%0d got=%0d want=%0d", inv, l, got_r(l), exp_r[l]); end
      if (got_i(l) != exp_i[l]) begin errors++; $display("[TB] FAIL kernel%0d_im%0d got=%0d want=%0d", inv, l, got_i(l), exp_i[l]); end
    end
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL kernel%0d_single got=%b want=0", inv, valid_o); end
  endtask

  task automatic test_scaling();
    int lat;
    beat_t b;
    b = '{inv: 1'b0, sc: 2'd2, re: pack4(127, 127, 127, 127), im: 32'h0};
    send_single(b, lat);
    checks += 2;
    if (got_r(0) != 127) begin errors++; $display("[TB] FAIL scale2_re0 got=%0d want=127", got_r(0)); end
    if (got_r(1) != 0) begin errors++; $display("[TB] FAIL scale2_re1 got=%0d want=0", got_r(1)); end
    b.sc = 2'd3;
    send_single(b, lat);
    checks++;
    if (got_r(0) != 127) begin errors++; $display("[TB] FAIL scale3_clamp got=%0d want=127", got_r(0)); end
    b = '{inv: 1'b0, sc: 2'd1, re: pack4(-128, -128, -128, -128), im: 32'h0};
    send_single(b, lat);
    checks += 2;
    if (got_r(0) != -256) begin errors++; $display("[TB] FAIL scale1_neg got=%0d want=-256", got_r(0)); end
    if (got_sr(0) != -128) begin errors++; $display("[TB] FAIL scale1_neg_sat got=%0d want=-128", got_sr(0)); end
  endtask

  task automatic test_saturation();
    int lat;
    beat_t hot, clean;
    hot   = '{inv: 1'b0, sc: 2'd0, re: pack4(127, 127, 127, 127), im: 32'h0};
    clean = '{inv: 1'b0, sc: 2'd0, re: pack4(1, 2, 3, 4), im: 32'h0};
`ifdef R4_BFLY_OVF_FLAG_EN
    ovf_clr = 1'b1; @(posedge clk); #1; ovf_clr = 1'b0;
    checks++;
    if (s_ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear0 got=%b want=0", s_ovf); end
`endif
    send_single(hot, lat);
    checks += 3;
    if (got_sr(0) != 127) begin errors++; $display("[TB] FAIL sat_re0 got=%0d want=127", got_sr(0)); end
    if (got_si(0) != 0) begin errors++; $display("[TB] FAIL sat_im0 got=%0d want=0", got_si(0)); end
    if (got_r(0) != 508) begin errors++; $display("[TB] FAIL wide_re0 got=%0d want=508", got_r(0)); end
`ifdef R4_BFLY_OVF_FLAG_EN
    checks += 2;
    if (s_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got=%b want=1", s_ovf); end
    if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_wide got=%b want=0", ovf); end
`endif
    send_single(clean, lat);
    checks++;
    if (got_sr(0) != 10) begin errors++; $display("[TB] FAIL sat_clean got=%0d want=10", got_sr(0)); end
`ifdef R4_BFLY_OVF_FLAG_EN
    checks++;
    if (s_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got=%b want=1", s_ovf); end
    ovf_clr = 1'b1; @(posedge clk); #1; ovf_clr = 1'b0;
    checks++;
    if (s_ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got=%b want=0", s_ovf); end
    // Clear held high across the edge that loads the saturating beat.
    present(hot);
    @(posedge clk); #1; valid_i = 1'b0; ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
    checks++;
    if (s_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set_wins got=%b want=1", s_ovf); end
`endif
    @(posedge clk); #1;
  endtask

  // Streams n beats through both instances with either the fixed 1-0-1-1-0
  // ready pattern or random ready/valid, checking order, values and stalls.
  task automatic test_stream(input int nbeats, input bit patterned);
    beat_t q[$];
    beat_t b, e;
    int sent, recv, cyc, pos;
    bit stalled;
    logic [OW*NP-1:0] prev_r, prev_i;
    sent = 0; recv = 0; cyc = 0; stalled = 1'b0; prev_r = '0; prev_i = '0;
    while (recv < nbeats && cyc < 400) begin
      @(posedge clk); #1;
      pos = cyc % 5;
      ready_i = patterned ? (pos != 1 && pos != 4) : ($urandom_range(0, 3) != 0);
      #1;
      if (valid_o) begin
        if (stalled) begin
          checks++;
          if (yr !== prev_r || yi !== prev_i) begin errors++; $display("[TB] FAIL stall_stable got=%h want=%h", yr, prev_r); end
        end
        if (ready_i) begin
          checks++;
          if (q.size() == 0) begin
            errors++; $display("[TB] FAIL stream_extra got=beat want=none");
          end else begin
            e = q.pop_front();
            recv++;
            for (int l = 0; l < NP; l++) begin
              checks += 4;
              if (got_r(l) != model_out(e, l, 1'b0, OW)) begin errors++; $display("[TB] FAIL stream_re%0d beat%0d got=%0d want=%0d", l, recv, got_r(l), model_out(e, l, 1'b0, OW)); end
              if (got_i(l) != model_out(e, l, 1'b1, OW)) begin errors++; $display("[TB] FAIL stream_im%0d beat%0d got=%0d want=%0d", l, recv, got_i(l), model_out(e, l, 1'b1, OW)); end
              if (got_sr(l) != model_out(e, l, 1'b0, OW_S)) begin errors++; $display("[TB] FAIL stream_sat_re%0d beat%0d got=%0d want=%0d", l, recv, got_sr(l), model_out(e, l, 1'b0, OW_S)); end
              if (got_si(l) != model_out(e, l, 1'b1, OW_S)) begin errors++; $display("[TB] FAIL stream_sat_im%0d beat%0d got=%0d want=%0d", l, recv, got_si(l), model_out(e, l, 1'b1, OW_S)); end
            end
          end
        end
      end
      checks += 2;
      if (ready_o !== !(valid_o && !ready_i)) begin errors++; $display("[TB] FAIL stream_ready got=%b want=%b", ready_o, !(valid_o && !ready_i)); end
      if (s_valid_o !== valid_o) begin errors++; $display("[TB] FAIL stream_sat_valid got=%b want=%b", s_valid_o, valid_o); end
      stalled = valid_o && !ready_i;
      prev_r = yr; prev_i = yi;
      b = '{inv: 1'($urandom_range(0, 1)), sc: 2'($urandom_range(0, 3)), re: $urandom, im: $urandom};
      if (sent < nbeats && (patterned || $urandom_range(0, 3) != 0)) begin
        present(b);
        if (ready_o) begin q.push_back(b); sent++; end
      end else begin
        valid_i = 1'b0; xr = b.re; xi = b.im;
      end
      cyc++;
    end
    checks++;
    if (recv != nbeats) begin errors++; $display("[TB] FAIL stream_count got=%0d want=%0d", recv, nbeats); end
    valid_i = 1'b0; ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain got=%b want=0", valid_o); end
    end
  endtask

  task automatic test_reset_midstream();
    int lat;
    beat_t b;
    b = '{inv: 1'b0, sc: 2'd0, re: pack4(1, 2, 3, 4), im: 32'h0};
    ready_i = 1'b1;
    present(b);
    @(posedge clk); #1;
    present(b);
    @(posedge clk); #1;
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL mid_inflight got=%b want=1", valid_o); end
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid got=%b want=0", valid_o); end
    if (yr !== '0 || yi !== '0) begin errors++; $display("[TB] FAIL mid_data got=%h want=0", yr); end
    if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got=%b want=1", ready_o); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_flushed got=%b want=0", valid_o); end
    send_single(b, lat);
    checks += 2;
    if (lat != 2) begin errors++; $display("[TB] FAIL mid_latency got=%0d want=2", lat); end
    if (got_r(0) != 10) begin errors++; $display("[TB] FAIL mid_re0 got=%0d want=10", got_r(0)); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_kernel(1'b0);
    test_kernel(1'b1);
    test_scaling();
    test_saturation();
    test_stream(6, 1'b1);
    test_stream(60, 1'b0);
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
